// File: rtl/pkt_rr_arbiter.sv
// pkt_rr_arbiter
//
// Packet-level round-robin arbiter. Shares one downstream packet channel
// between N_REQ upstream sources. It grants one source at a time and holds
// that grant from the first beat of a packet to its last beat.
//
// Handshake: a beat moves on a rising edge when valid and ready are both
// high on that channel. A source may drop valid at any time; ready never
// depends on the valid of the same channel.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   [N_REQ]         per-requester beat valid
//   in_data    [N_REQ*DATA_W]  per-requester payload, requester i at [i*DATA_W +: DATA_W]
//   in_last    [N_REQ]         per-requester last-beat flag
//   in_ready   [N_REQ]         per-requester beat accept
//   out_valid  granted beat valid
//   out_data   [DATA_W]        granted payload
//   out_last   granted last flag
//   out_ready  downstream accept
//   out_src    [SRC_W]         index of current / most recent grant
//   busy       high while a packet is locked (FSM state is LOCKED)
//   pkt_count  [16]            completed packets, wraps silently
module pkt_rr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int SRC_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        in_valid,
    input  logic [N_REQ*DATA_W-1:0] in_data,
    input  logic [N_REQ-1:0]        in_last,
    output logic [N_REQ-1:0]        in_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [SRC_W-1:0]        out_src,
    output logic                    busy,
    output logic [15:0]             pkt_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [SRC_W-1:0] ptr, ptr_next;
    logic [SRC_W-1:0] grant, grant_next;
    logic [15:0]      count, count_next;

    logic             found;
    logic [SRC_W-1:0] winner;

    // Unpack the flat payload bus so the granted lane can be selected by index.
    logic [DATA_W-1:0] data_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = in_data[i*DATA_W +: DATA_W];
    end

    // Round-robin scan starting at ptr. The sum is one bit wider than an
    // index so the wrap test works for any N_REQ, power of two or not.
    always_comb begin : arb_scan
        logic [SRC_W:0] sum;
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (SRC_W+1)'(k);
            if (sum >= (SRC_W+1)'(N_REQ)) begin
                sum = sum - (SRC_W+1)'(N_REQ);
            end
            if (!found && in_valid[sum[SRC_W-1:0]]) begin
                found  = 1'b1;
                winner = sum[SRC_W-1:0];
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        grant_next = grant;
        count_next = count;
        in_ready   = '0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    grant_next = winner;
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                out_valid       = in_valid[grant];
                out_data        = data_arr[grant];
                out_last        = in_last[grant];
                in_ready[grant] = out_ready;
                // Only a completed packet moves the pointer; a grant alone
                // leaves it where it is.
                if (in_valid[grant] && out_ready && in_last[grant]) begin
                    state_next = IDLE;
                    ptr_next   = (grant == SRC_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
                    count_next = count + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            grant <= grant_next;
            count <= count_next;
        end
    end

    assign out_src   = grant;
    assign busy      = (state == LOCKED);
    assign pkt_count = count;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Bench for pkt_rr_arbiter. Packets are queued per requester; a packet-level
// round-robin model orders them into the expected beat queue, and a monitor
// checks every accepted output beat against it.
module tb_pkt_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int W  = SW + 1 + DW;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_ready;
  logic [SW-1:0]   out_src;
  logic            busy;
  logic [15:0]     pkt_count;

  pkt_rr_arbiter #(.N_REQ(N), .DATA_W(DW), .SRC_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .out_src   (out_src),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  int checks = 0;
  int errors = 0;

  logic [W-1:0]  exp_q[$];          // {src, last, data}
  logic [DW:0]   drv_q [N][$];      // {last, data} beats still to be sent
  logic [DW:0]   mdl_q [N][$];      // same beats, not yet ordered by the model
  int            mdl_len [N][$];    // packet lengths, not yet ordered
  int            mptr   = 0;        // model round-robin pointer
  int            mcount = 0;        // model completed-packet count
  bit            drv_en = 1'b0;
  bit            gap_en = 1'b0;
  int            ready_pct = 100;
  bit            started [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- driver ----------------
  initial begin
    logic [N-1:0] fired;
    logic [DW:0]  b;
    forever begin
      @(negedge clk);
      fired = in_valid & in_ready;
      @(posedge clk);
      #1;
      if (drv_en) begin
        if (rst) begin
          for (int i = 0; i < N; i++) begin
            drv_q[i].delete();
            started[i] = 1'b0;
          end
        end else begin
          for (int i = 0; i < N; i++) begin
            if (fired[i] && drv_q[i].size() > 0) begin
              b = drv_q[i].pop_front();
              started[i] = !b[DW];
            end
          end
        end
        for (int i = 0; i < N; i++) begin
          if (drv_q[i].size() > 0 && !(gap_en && started[i] && $urandom_range(0, 3) == 0)) begin
            b = drv_q[i][0];
            in_valid[i]          = 1'b1;
            in_data[i*DW +: DW]  = b[DW-1:0];
            in_last[i]           = b[DW];
          end else begin
            in_valid[i]          = 1'b0;
            in_data[i*DW +: DW]  = $urandom;
            in_last[i]           = 1'($urandom_range(0, 1));
          end
        end
        out_ready = ($urandom_range(1, 100) <= ready_pct);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit           bub;
    bit           lat_pend;
    logic [W-1:0] e;
    logic [N-1:0] exp_rdy;
    logic [SW-1:0] hsrc;
    bub      = 1'b0;
    lat_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !drv_en) begin
        bub      = 1'b0;
        lat_pend = 1'b0;
      end else begin
        if (lat_pend) chk("grant_latency", 64'(busy), 64'd1);
        if (bub) chk("bubble_after_last", {busy, out_valid}, 64'd0);
        bub      = 1'b0;
        lat_pend = !busy && (|in_valid);
        if (!busy) chk("idle_outputs", {out_valid, out_last, out_data, in_ready}, 64'd0);
        exp_rdy = '0;
        if (out_ready && exp_q.size() > 0) begin
          e    = exp_q[0];
          hsrc = e[W-1 -: SW];
          exp_rdy[hsrc] = 1'b1;
        end
        if (in_ready != '0 || !out_ready) chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got src %0d data 0x%0h with nothing expected at %0t",
                     out_src, out_data, $time);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {out_src, out_last, out_data}, 64'(e));
            if (e[DW]) bub = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic add_pkt(input int src, input int len, input bit fixed, input logic [DW-1:0] base);
    logic [DW-1:0] d;
    logic          l;
    mdl_len[src].push_back(len);
    for (int b = 0; b < len; b++) begin
      d = fixed ? base + DW'(b) : DW'($urandom);
      l = (b == len - 1);
      drv_q[src].push_back({l, d});
      mdl_q[src].push_back({l, d});
    end
  endtask

  // Order all pending packets: repeatedly take the first requester at or
  // after the pointer that has a packet, emit that whole packet, and move
  // the pointer just past it.
  task automatic build_expected();
    int g;
    int len;
    bit any;
    logic [DW:0] beat;
    forever begin
      any = 1'b0;
      g   = 0;
      for (int k = 0; k < N; k++) begin
        if (!any && mdl_len[(mptr + k) % N].size() > 0) begin
          g   = (mptr + k) % N;
          any = 1'b1;
        end
      end
      if (!any) break;
      len = mdl_len[g].pop_front();
      for (int b = 0; b < len; b++) begin
        beat = mdl_q[g].pop_front();
        exp_q.push_back({SW'(g), beat});
      end
      mptr   = (g + 1) % N;
      mcount = (mcount + 1) % 65536;
    end
  endtask

  function automatic bit drv_pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < N; i++) if (drv_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() > 0 || drv_pending()) && cyc < 3000) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    chk({name, "_pkt_count"}, 64'(pkt_count), 64'(mcount));
    chk({name, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  task automatic run_phase(input string name);
    build_expected();
    wait_drain(name);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    rst       = 1'b1;
    in_valid  = '1;
    in_last   = '1;
    in_data   = '1;
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #2;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", {out_valid, out_last, out_data}, 64'd0);
      chk("rst_out_src", 64'(out_src), 64'd0);
      chk("rst_pkt_count", 64'(pkt_count), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end
    rst      = 1'b0;
    in_valid = '0;
    in_last  = '0;
    drv_en   = 1'b1;

    // single source, 3-beat packet
    ready_pct = 100;
    gap_en    = 1'b0;
    add_pkt(0, 3, 1'b1, 32'hA0);
    run_phase("single");

    // fairness: every requester offers two 1-beat packets
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) add_pkt(i, 1, 1'b1, DW'(32'h100 + 16 * i + r));
    run_phase("fair");

    // backpressure on a 4-beat packet
    ready_pct = 40;
    add_pkt(1, 4, 1'b1, 32'hB0);
    run_phase("backpressure");

    // lock hold: requester 2 pauses mid-packet while 3 waits
    ready_pct = 100;
    gap_en    = 1'b1;
    add_pkt(2, 6, 1'b1, 32'hC0);
    add_pkt(3, 2, 1'b1, 32'hD0);
    run_phase("lock_hold");

    // randomized contention
    repeat (25) begin
      ready_pct = $urandom_range(30, 100);
      for (int i = 0; i < N; i++) begin
        int n;
        n = $urandom_range(0, 3);
        repeat (n) add_pkt(i, $urandom_range(1, 6), 1'b0, '0);
      end
      run_phase("random");
    end

    // leave the pointer at 2 so a missing pointer reset would be visible
    ready_pct = 100;
    gap_en    = 1'b0;
    add_pkt(1, 1, 1'b1, 32'hE0);
    run_phase("pre_reset");

    // reset in the middle of a 3-beat packet from requester 3
    add_pkt(3, 3, 1'b1, 32'hF0);
    build_expected();
    cyc = 0;
    while (drv_q[3].size() != 2 && cyc < 200) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    chk("mid_pkt_first_beat_sent", 64'(drv_q[3].size()), 64'd2);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    mptr   = 0;
    mcount = 0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("mid_rst_outputs", {out_valid, out_last, out_data, in_ready}, 64'd0);
    chk("mid_rst_out_src", 64'(out_src), 64'd0);

    // after reset the pointer is 0: requester 1 must win over requester 3
    add_pkt(3, 2, 1'b1, 32'h130);
    add_pkt(1, 2, 1'b1, 32'h110);
    run_phase("post_reset");

    gap_en = 1'b1;
    repeat (5) begin
      ready_pct = $urandom_range(50, 100);
      for (int i = 0; i < N; i++) begin
        int n;
        n = $urandom_range(0, 2);
        repeat (n) add_pkt(i, $urandom_range(1, 4), 1'b0, '0);
      end
      run_phase("random_tail");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
